// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I integer core: fetch, decode, execute, memory access and
// writeback all complete within one clock. Instruction memory, data memory and
// the 32x32 register file live inside the block; only clk and rst are pins.
module rv32i_single_cycle_core #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

    // Architectural storage
    logic [31:0] instr_mem [0:IMEM_WORDS-1];
    logic [31:0] data_mem  [0:DMEM_WORDS-1];
    logic [31:0] registers [0:31];
    logic [31:0] pc;

    // Datapath
    logic [31:0] instruction, read_data1, read_data2, alu_in2, alu_result;
    logic [31:0] write_data, mem_data;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_5;
    opcode_t     opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] pc_plus4, next_pc;

    // Control
    logic    Branch, Jump, RegWrite, MemRead, MemWrite;
    logic    use_rs2;
    alu_op_t alu_op;
    wb_sel_t wb_sel;

    // Funct3/funct7 to ALU operation; bit 30 only selects SUB for R-type,
    // so an ADDI with imm[10] set still adds.
    function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign instruction = instr_mem[pc[IW+1:2]];
    assign opcode      = opcode_t'(instruction[6:0]);
    assign rd          = instruction[11:7];
    assign funct3      = instruction[14:12];
    assign rs1         = instruction[19:15];
    assign rs2         = instruction[24:20];
    assign funct7_5    = instruction[30];

    assign imm_i = {{21{instruction[31]}}, instruction[30:20]};
    assign imm_s = {{21{instruction[31]}}, instruction[30:25], instruction[11:7]};
    assign imm_b = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};

    assign read_data1 = (rs1 == 5'd0) ? 32'd0 : registers[rs1];
    assign read_data2 = (rs2 == 5'd0) ? 32'd0 : registers[rs2];
    assign pc_plus4   = pc + 32'd4;

    // Main decoder: opcode to control lines; unknown opcodes fall through as a no-op.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        use_rs2  = 1'b0;
        alu_op   = ALU_ADD;
        wb_sel   = WB_ALU;
        case (opcode)
            OP_R:      begin RegWrite = 1'b1; use_rs2 = 1'b1; alu_op = decode_alu(funct3, funct7_5, 1'b1); end
            OP_I:      begin RegWrite = 1'b1; alu_op = decode_alu(funct3, funct7_5, 1'b0); end
            OP_LOAD:   begin RegWrite = 1'b1; MemRead = 1'b1; wb_sel = WB_MEM; end
            OP_STORE:  MemWrite = 1'b1;
            OP_BRANCH: begin Branch = 1'b1; use_rs2 = 1'b1; end
            OP_JAL,
            OP_JALR:   begin Jump = 1'b1; RegWrite = 1'b1; wb_sel = WB_PC4; end
            OP_LUI:    begin RegWrite = 1'b1; wb_sel = WB_IMM; end
            default:   ;
        endcase
    end

    assign alu_in2 = use_rs2 ? read_data2 : (MemWrite ? imm_s : imm_i);

    // ALU: 32-bit wrapping arithmetic, shifts use the low five bits of the operand.
    always_comb begin
        case (alu_op)
            ALU_SUB:  alu_result = read_data1 - alu_in2;
            ALU_AND:  alu_result = read_data1 & alu_in2;
            ALU_OR:   alu_result = read_data1 | alu_in2;
            ALU_XOR:  alu_result = read_data1 ^ alu_in2;
            ALU_SLL:  alu_result = read_data1 << alu_in2[4:0];
            ALU_SRL:  alu_result = read_data1 >> alu_in2[4:0];
            ALU_SRA:  alu_result = $signed(read_data1) >>> alu_in2[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(read_data1) < $signed(alu_in2)};
            ALU_SLTU: alu_result = {31'd0, read_data1 < alu_in2};
            default:  alu_result = read_data1 + alu_in2;
        endcase
    end

    assign mem_data = data_mem[alu_result[DW+1:2]];

    // Writeback source selection.
    always_comb begin
        case (wb_sel)
            WB_MEM:  write_data = mem_data;
            WB_PC4:  write_data = pc_plus4;
            WB_IMM:  write_data = imm_u;
            default: write_data = alu_result;
        endcase
    end

    // Next-PC: sequential, taken BEQ/BNE, JAL target, or JALR target with bit 0 cleared.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = (opcode == OP_JALR) ? (alu_result & ~32'd1) : (pc + imm_j);
        end else if (Branch) begin
            if ((funct3 == 3'b000 && read_data1 == read_data2) ||
                (funct3 == 3'b001 && read_data1 != read_data2))
                next_pc = pc + imm_b;
        end
    end

    // PC and register file update; reset clears both, x0 is never written.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
        if (!rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (RegWrite && rd != 5'd0) registers[rd] <= write_data;
        end
    end

    // Store port of data memory.
    always_ff @(posedge clk) begin
        // NOTE: memory contents are deliberately not reset; preloaded data must survive reset.
        if (rst && MemWrite) data_mem[alu_result[DW+1:2]] <= read_data2;
    end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Self-checking bench for rv32i_single_cycle_core: directed programs from the
// test plan followed by a long random program, all compared each cycle against
// an instruction-set-level reference model.
module tb_rv32i_single_cycle_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv32i_single_cycle_core #(
        .IMEM_WORDS(1024),
        .DMEM_WORDS(1024),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_imem [1024];
    logic [31:0] m_dmem [1024];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          m_store_idx = -1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    task automatic put_instr(input int idx, input logic [31:0] w);
        dut.instr_mem[idx] = w;
        m_imem[idx] = w;
    endtask

    task automatic put_data(input int idx, input logic [31:0] w);
        dut.data_mem[idx] = w;
        m_dmem[idx] = w;
    endtask

    // Executes one instruction at the ISA level.
    task automatic model_step();
        logic [31:0] ins, a, b, res, addr, npc, ii, is, ib, ij;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic        wr;
        ins = m_imem[m_pc[11:2]];
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        alt = ins[30];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        a   = (rs1 == 5'd0) ? 32'd0 : m_regs[rs1];
        b   = (rs2 == 5'd0) ? 32'd0 : m_regs[rs2];
        npc = m_pc + 32'd4;
        res = 32'd0;
        wr  = 1'b0;
        m_store_idx = -1;
        if (op == 7'h13) b = ii;
        case (op)
            7'h33, 7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: res = (op == 7'h33 && alt) ? a - b : a + b;
                    3'd1: res = a << b[4:0];
                    3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            7'h03: begin
                addr = a + ii;
                res  = m_dmem[addr[11:2]];
                wr   = 1'b1;
            end
            7'h23: begin
                addr = a + is;
                m_dmem[addr[11:2]] = b;
                m_store_idx = int'(addr[11:2]);
            end
            7'h63: begin
                if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b)) npc = m_pc + ib;
            end
            7'h6F: begin res = m_pc + 32'd4; wr = 1'b1; npc = m_pc + ij; end
            7'h67: begin res = m_pc + 32'd4; wr = 1'b1; npc = (a + ii) & 32'hFFFF_FFFE; end
            7'h37: begin res = {ins[31:12], 12'h000}; wr = 1'b1; end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_regs[rd] = res;
        m_pc = npc;
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s.x%0d", tag, i), dut.registers[i], m_regs[i]);
        if (m_store_idx >= 0)
            check($sformatf("%s.dmem[%0d]", tag, m_store_idx), dut.data_mem[m_store_idx], m_dmem[m_store_idx]);
    endtask

    // One clock: advance model, let the DUT take its edge, compare at the falling edge.
    task automatic step(input string tag);
        model_step();
        @(negedge clk);
        compare_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_store_idx = -1;
        check({tag, ".pc"}, dut.pc, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s.x%0d", tag, i), dut.registers[i], 32'd0);
        for (int i = 0; i < 1024; i++)
            if (dut.data_mem[i] !== m_dmem[i])
                check($sformatf("%s.dmem[%0d]", tag, i), dut.data_mem[i], m_dmem[i]);
        check({tag, ".dmem2"}, dut.data_mem[2], m_dmem[2]);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  bad [4];
        bad = '{7'h17, 7'h0F, 7'h73, 7'h7F};
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 10))
            0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd);
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
            5: return enc_s(imm, rs2, rs1);
            6: return enc_b({imm, 1'b0}, rs2, rs1, {2'b00, f3[0]});
            7: return enc_j({9'($urandom), imm}, rd);
            8: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
            9: return enc_u(20'($urandom), rd);
            default: return {25'($urandom), bad[$urandom_range(0, 3)]};
        endcase
    endfunction

    initial begin
        // Preload: NOP-filled instruction memory, random data memory, data_mem[2]=0xA.
        for (int i = 0; i < 1024; i++) begin
            put_instr(i, NOP);
            put_data(i, $urandom);
        end
        put_data(2, 32'h0000_000A);

        put_instr(0,  enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));       // ADDI x1,x0,5
        put_instr(1,  enc_i(12'd3, 5'd0, 3'd0, 5'd2, 7'h13));       // ADDI x2,x0,3
        put_instr(2,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));        // ADD x3,x1,x2
        put_instr(3,  enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4));        // SUB x4,x2,x1
        put_instr(4,  enc_b(13'd16, 5'd4, 5'd3, 3'd0));             // BEQ x3,x4,16
        put_instr(8,  enc_j(21'd8, 5'd1));                          // JAL x1,8
        put_instr(9,  enc_j(21'h24, 5'd0));                         // JAL x0,+0x24 -> 0x48
        put_instr(10, enc_s(12'd8, 5'd10, 5'd0));                   // SW x10,8(x0)
        put_instr(11, enc_i(12'd8, 5'd0, 3'd2, 5'd12, 7'h03));      // LW x12,8(x0)
        put_instr(12, enc_u(20'd1, 5'd10));                         // LUI x10,1
        put_instr(13, enc_i(12'h234, 5'd10, 3'd0, 5'd10, 7'h13));   // ADDI x10,x10,0x234
        put_instr(14, enc_s(12'd8, 5'd10, 5'd0));                   // SW x10,8(x0)
        put_instr(15, enc_i(12'd8, 5'd0, 3'd2, 5'd12, 7'h03));      // LW x12,8(x0)
        put_instr(16, enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13));       // ADDI x0,x0,7
        put_instr(17, enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));       // JALR x0,0(x1)

        // Arithmetic and branch not taken
        do_reset("reset1");
        for (int i = 0; i < 4; i++) step($sformatf("arith%0d", i));
        check("x1", dut.registers[1], 32'd5);
        check("x2", dut.registers[2], 32'd3);
        check("x3", dut.registers[3], 32'd8);
        check("x4", dut.registers[4], 32'hFFFF_FFFE);
        step("beq_nt");
        check("beq_nt.pc", dut.pc, 32'h14);
        check("beq_nt.x3", dut.registers[3], 32'd8);

        // Branch taken, jumps, store/load round trip
        put_instr(4, enc_b(13'd16, 5'd1, 5'd1, 3'd0));              // BEQ x1,x1,16
        do_reset("reset2");
        for (int i = 0; i < 5; i++) step($sformatf("prog%0d", i));
        check("beq_t.pc", dut.pc, 32'h20);
        step("jal");
        check("jal.x1", dut.registers[1], 32'h24);
        check("jal.pc", dut.pc, 32'h28);
        step("sw0");
        check("sw0.dmem2", dut.data_mem[2], 32'd0);
        step("lw0");
        check("lw0.x12", dut.registers[12], 32'd0);
        for (int i = 0; i < 4; i++) step($sformatf("ldst%0d", i));
        check("lw1.x12", dut.registers[12], 32'h1234);
        check("sw1.dmem2", dut.data_mem[2], 32'h1234);
        step("wr_x0");
        check("wr_x0.x0", dut.registers[0], 32'd0);
        step("jalr");
        check("jalr.pc", dut.pc, 32'h24);
        step("jal_skip");
        check("jal_skip.pc", dut.pc, 32'h48);

        // Idle NOP execution: only pc moves
        for (int i = 0; i < 200; i++) step("idle");
        check("idle.pc", dut.pc, 32'h48 + 32'd800);
        check("idle.x1", dut.registers[1], 32'h24);
        check("idle.x10", dut.registers[10], 32'h1234);
        check("idle.x12", dut.registers[12], 32'h1234);
        check("idle.dmem2", dut.data_mem[2], 32'h1234);

        // Random program over the whole instruction memory
        for (int i = 0; i < 1024; i++) begin
            put_instr(i, rand_instr());
            put_data(i, $urandom);
        end
        do_reset("reset3");
        for (int i = 0; i < 2000; i++) step("rand");
        for (int i = 0; i < 1024; i++)
            if (dut.data_mem[i] !== m_dmem[i])
                check($sformatf("rand.final_dmem[%0d]", i), dut.data_mem[i], m_dmem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_single_cycle_core.md
Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer core: one instruction fetched, decoded, executed and retired per clock.
- Contains its own instruction memory, data memory and 32x32 register file.
- Top-level CPU block in simulation; benches preload memories and inspect state through fixed hierarchical names.
- Only external pins are clock and reset.

Parameters:
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.

Behaviour:
- Required internal names (bench probes these):
  - Storage: instr_mem[0:1023], data_mem[0:1023], registers[0:31], pc.
  - Datapath: instruction, read_data1, read_data2, alu_in2, alu_result, write_data, mem_data, rd.
  - Control: Branch, Jump, RegWrite, MemRead, MemWrite.
  - All 32-bit except rd (5-bit) and the single-bit controls.
- Reset:
  - rst==0 at a rising edge: pc<=RESET_PC; registers[0..31]<=0.
  - instr_mem and data_mem are not touched by reset; benches preload them.
  - No register or memory writes occur in a reset cycle.
- Fetch and decode:
  - instruction = instr_mem[pc[11:2]], combinational.
  - pc[1:0] ignored; out-of-range index wraps modulo 1024.
  - Register reads are combinational: read_data1=registers[rs1], read_data2=registers[rs2].
  - x0 always reads 0 and is never written.
- Supported instructions:
  - R-type (0110011): ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - Memory: LW (0000011), SW (0100011).
  - Branches (1100011): BEQ, BNE.
  - Jumps and upper: JAL (1101111), JALR (1100111), LUI (0110111).
- Operands and immediates:
  - alu_in2 = read_data2 for R-type and branches, sign-extended immediate otherwise.
  - Immediate formats are standard I/S/B/J/U.
  - Arithmetic is 32-bit modulo 2^32; shift amount is low 5 bits.
  - SLT is signed; SLTU is unsigned.
- Memory access:
  - LW: write_data = mem_data = data_mem[alu_result[11:2]], read combinationally (MemRead=1).
  - SW: data_mem[alu_result[11:2]] <= read_data2 at the edge (MemWrite=1).
  - Address low bits are ignored, no misalignment trap; index wraps modulo 1024.
- Next PC:
  - Default: pc+4.
  - Branch=1 and condition true: pc+B-imm. BEQ is taken when equal, BNE when not equal.
  - JAL: pc+J-imm, with rd<=pc+4 (Jump=1).
  - JALR: (read_data1+I-imm)&~1, with rd<=pc+4 (Jump=1).
- Writeback:
  - RegWrite=1 for R, I-ALU, LW, JAL, JALR, LUI.
  - write_data is the ALU result, load data, pc+4 or U-imm as appropriate.
  - Written at the rising edge; a write to rd=0 is discarded.
- Unsupported or illegal opcode:
  - All of RegWrite, MemWrite, MemRead, Branch and Jump are 0.
  - pc advances by 4; no trap.
- Timing and hazards:
  - A read-after-write to the same register in the next instruction sees the updated value (single-cycle, no hazards).
  - CPI=1; no stalls.

Test Plan:
- Reset: hold rst=0 two cycles -> pc=0, all registers 0, preloaded memory contents unchanged. Release rst=1 -> pc steps 0,4,8,...
- Arithmetic: program ADDI x1,x0,5 / ADDI x2,x0,3 / ADD x3,x1,x2 / SUB x4,x2,x1 -> x1=5, x2=3, x3=8, x4=FFFFFFFE.
- Branch not taken: follow with BEQ x3,x4,16 (8≠-2) -> next pc is +4, no register write.
- Branch taken: BEQ x1,x1,16 at pc=0x10 -> pc=0x20.
- Store/load round trip: data_mem[2]=0xA preloaded; SW x10,8(x0) with x10=0 then LW x12,8(x0) -> data_mem[2]=0, x12=0. With x10=0x1234 -> x12=0x1234.
- Jumps: JAL x1,8 at pc=0x20 -> x1=0x24, pc=0x28. JALR x0,0(x1) -> pc=0x24. Writes to x0 leave x0=0.
- Idle execution: 200 cycles of NOP (0x00000013) -> only pc changes; registers and memory are stable.
